// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for bus_arbiter: FSM state encoding and default bus widths.
package bus_arbiter_pkg;

  localparam int BUS_ADDR_W = 64;
  localparam int BUS_DATA_W = 64;
  localparam int BUS_INST_W = 32;
  localparam int BUS_MASK_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_D_REQ  = 3'd1,
    ST_D_WAIT = 3'd2,
    ST_D_DONE = 3'd3,
    ST_I_REQ  = 3'd4,
    ST_I_WAIT = 3'd5,
    ST_I_HOLD = 3'd6
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter.sv
// Serialises the core's fetch and load/store ports onto one request/response bus, data first.
// Optional response watchdog and sticky bus_err output: define BUS_ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W,
  parameter int INST_W = BUS_INST_W
`ifdef BUS_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 256
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     inst_addr,
  input  logic                  inst_ena,
  input  logic                  inst_ready,
  output logic [INST_W-1:0]     inst,
  output logic                  inst_valid,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [BUS_MASK_W-1:0] wmask,
  input  logic [DATA_W-1:0]     data_o,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_W-1:0]     data_i,
  output logic                  mem_finish,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [BUS_MASK_W-1:0] bus_wmask,
  input  logic                  bus_rvalid,
  input  logic [DATA_W-1:0]     bus_rdata
`ifdef BUS_ARB_TIMEOUT_EN
  ,
  output logic                  bus_err
`endif
);

  arb_state_t              r_state, w_state_nxt;
  logic [INST_W-1:0]       r_inst, w_inst;
  logic                    r_inst_valid, w_inst_valid;
  logic [DATA_W-1:0]       r_data_i, w_data_i;
  logic                    r_mem_finish, w_mem_finish;
  logic                    r_bus_valid, w_bus_valid;
  logic                    r_bus_we, w_bus_we;
  logic [ADDR_W-1:0]       r_bus_addr, w_bus_addr;
  logic [DATA_W-1:0]       r_bus_wdata, w_bus_wdata;
  logic [BUS_MASK_W-1:0]   r_bus_wmask, w_bus_wmask;
  logic [ADDR_W-1:0]       r_ireq_addr, w_ireq_addr;

  logic                    w_resp;
  logic [DATA_W-1:0]       w_rdata;
  logic                    w_fetch_match;
  logic [INST_W-1:0]       w_inst_sel;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_bus_err;
  logic             w_waiting;
  logic             w_tmo;

  assign w_waiting = (r_state == ST_D_WAIT) || (r_state == ST_I_WAIT);
  assign w_tmo     = w_waiting && (r_tmo_cnt == CNT_W'(TIMEOUT_CYC));

  // A real response in the expiry cycle wins; only a synthesised one flags an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (!w_waiting)
        r_tmo_cnt <= '0;
      else if (!w_tmo)
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_tmo && !bus_rvalid)
        r_bus_err <= 1'b1;
    end
  end

  assign w_resp  = bus_rvalid | w_tmo;
  assign w_rdata = bus_rvalid ? bus_rdata : '0;
  assign bus_err = r_bus_err;
`else
  assign w_resp  = bus_rvalid;
  assign w_rdata = bus_rdata;
`endif

  assign w_fetch_match = (inst_addr == r_ireq_addr);
  assign w_inst_sel    = r_ireq_addr[2] ? w_rdata[2*INST_W-1:INST_W] : w_rdata[INST_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
      r_data_i     <= '0;
      r_mem_finish <= 1'b0;
      r_bus_valid  <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_bus_wmask  <= '0;
      r_ireq_addr  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_inst       <= w_inst;
      r_inst_valid <= w_inst_valid;
      r_data_i     <= w_data_i;
      r_mem_finish <= w_mem_finish;
      r_bus_valid  <= w_bus_valid;
      r_bus_we     <= w_bus_we;
      r_bus_addr   <= w_bus_addr;
      r_bus_wdata  <= w_bus_wdata;
      r_bus_wmask  <= w_bus_wmask;
      r_ireq_addr  <= w_ireq_addr;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (we || re)
          w_state_nxt = ST_D_REQ;
        else if (inst_ena)
          w_state_nxt = ST_I_REQ;
      end
      ST_D_REQ:  if (bus_ready) w_state_nxt = ST_D_WAIT;
      ST_D_WAIT: if (w_resp)    w_state_nxt = ST_D_DONE;
      ST_D_DONE: w_state_nxt = ST_IDLE;
      ST_I_REQ:  if (bus_ready) w_state_nxt = ST_I_WAIT;
      // A fetch whose PC moved on while in flight is stale and is dropped.
      ST_I_WAIT: if (w_resp) w_state_nxt = w_fetch_match ? ST_I_HOLD : ST_IDLE;
      ST_I_HOLD: if (!w_fetch_match || inst_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_inst       = r_inst;
    w_data_i     = r_data_i;
    w_bus_we     = r_bus_we;
    w_bus_addr   = r_bus_addr;
    w_bus_wdata  = r_bus_wdata;
    w_bus_wmask  = r_bus_wmask;
    w_ireq_addr  = r_ireq_addr;
    w_bus_valid  = (w_state_nxt == ST_D_REQ) || (w_state_nxt == ST_I_REQ);
    w_mem_finish = (w_state_nxt == ST_D_DONE);
    w_inst_valid = (w_state_nxt == ST_I_HOLD);
    unique case (r_state)
      ST_IDLE: begin
        if (w_state_nxt == ST_D_REQ) begin
          w_bus_addr  = data_addr;
          w_bus_wdata = data_o;
          w_bus_wmask = wmask;
          w_bus_we    = we;
        end else if (w_state_nxt == ST_I_REQ) begin
          w_bus_addr  = {inst_addr[ADDR_W-1:3], 3'b000};
          w_bus_wmask = '0;
          w_bus_we    = 1'b0;
          w_ireq_addr = inst_addr;
        end
      end
      ST_D_WAIT: if (w_resp) w_data_i = w_rdata;
      ST_I_WAIT: if (w_resp && w_fetch_match) w_inst = w_inst_sel;
      default: ;
    endcase
  end

  assign inst       = r_inst;
  assign inst_valid = r_inst_valid;
  assign data_i     = r_data_i;
  assign mem_finish = r_mem_finish;
  assign bus_valid  = r_bus_valid;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign bus_wmask  = r_bus_wmask;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, corner-case sequences and randomized transactions.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] inst_addr = '0;
  logic        inst_ena = 1'b0;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [63:0] data_addr = '0;
  logic [7:0]  wmask = '0;
  logic [63:0] data_o = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [63:0] data_i;
  logic        mem_finish;
  logic        bus_valid;
  logic        bus_ready = 1'b0;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wmask;
  logic        bus_rvalid = 1'b0;
  logic [63:0] bus_rdata = '0;
`ifdef BUS_ARB_TIMEOUT_EN
  logic        bus_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

`ifdef BUS_ARB_TIMEOUT_EN
  bus_arbiter #(.ADDR_W(64), .DATA_W(64), .INST_W(32), .TIMEOUT_CYC(16)) dut (
`else
  bus_arbiter #(.ADDR_W(64), .DATA_W(64), .INST_W(32)) dut (
`endif
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .inst_ena(inst_ena), .inst_ready(inst_ready),
    .inst(inst), .inst_valid(inst_valid),
    .data_addr(data_addr), .wmask(wmask), .data_o(data_o), .we(we), .re(re),
    .data_i(data_i), .mem_finish(mem_finish),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
`ifdef BUS_ARB_TIMEOUT_EN
    , .bus_err(bus_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model. kind: 0 load, 1 store, 2 fetch, 3 load+store together.
  function automatic logic [63:0] m_baddr(int kind, logic [63:0] a);
    return (kind == 2) ? (a - (a % 8)) : a;
  endfunction

  function automatic logic m_we(int kind);
    return (kind == 1) || (kind == 3);
  endfunction

  function automatic logic [63:0] m_res(int kind, logic [63:0] a, logic [63:0] rd);
    int sh;
    if (kind != 2) return rd;
    sh = ((a % 8) >= 4) ? 32 : 0;
    return (rd >> sh) & 64'hFFFF_FFFF;
  endfunction

  // Runs one transaction from a negedge with the arbiter idle; ends at a negedge, idle again.
  task automatic do_txn(input int kind, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [7:0] wm, input logic [63:0] rd, input int rdy, input int rv,
                        input int hold, input logic [63:0] ebaddr, input logic ewe,
                        input logic [63:0] eres, input bit noise, input string nm);
    int t = 0;
    int vcnt = 0;
    int rvc = 0;
    int tdone = -1;
    int extra = 0;
    bit acc = 0;
    bit pay_ok = 1;
    bit hold_ok = 1;
    bit isf = (kind == 2);
    if (isf) begin
      inst_addr = addr;
      inst_ena  = 1'b1;
    end else begin
      data_addr = addr;
      data_o    = wd;
      wmask     = wm;
      we        = (kind == 1) || (kind == 3);
      re        = (kind == 0) || (kind == 3);
    end
    while (tdone < 0 && t < 100) begin
      @(negedge clk);
      t++;
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = {$urandom, $urandom};
      if (isf ? inst_valid : mem_finish) begin
        tdone = t;
      end else if (bus_valid) begin
        if (bus_addr !== ebaddr || bus_we !== ewe ||
            (ewe && (bus_wdata !== wd || bus_wmask !== wm)))
          pay_ok = 0;
        if (vcnt >= rdy) begin
          bus_ready = 1'b1;
          acc = 1;
        end
        if (noise) bus_rvalid = 1'($urandom_range(0, 1));
        vcnt++;
      end else if (acc) begin
        if (rvc == rv) begin
          bus_rvalid = 1'b1;
          bus_rdata  = rd;
        end
        rvc++;
      end
    end
    chk({nm, " payload"}, 64'(pay_ok && (vcnt == rdy + 1)), 64'd1);
    chk({nm, " latency"}, 64'(tdone), 64'(3 + rdy + rv));
    if (!isf) begin
      chk({nm, " data_i"}, data_i, eres);
      we = 1'b0;
      re = 1'b0;
      repeat (2) begin
        @(negedge clk);
        if (mem_finish || bus_valid) extra++;
      end
      chk({nm, " single finish"}, 64'(extra), 64'd0);
    end else begin
      chk({nm, " inst"}, {32'h0, inst}, eres);
      inst_ena = 1'b0;
      for (int i = 1; i < hold; i++) begin
        @(negedge clk);
        if (!inst_valid) hold_ok = 0;
      end
      chk({nm, " hold"}, 64'(hold_ok), 64'd1);
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      chk({nm, " valid cleared"}, 64'(inst_valid), 64'd0);
      @(negedge clk);
      chk({nm, " idle after"}, 64'(bus_valid), 64'd0);
    end
  endtask

  typedef struct {
    int          kind;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [7:0]  wm;
    logic [63:0] rd;
    int          rdy;
    int          rv;
    int          hold;
    logic [63:0] ebaddr;
    logic        ewe;
    logic [63:0] eres;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int found;
    int kind;
    logic [63:0] a, wd, rd;
    logic [7:0] wm;

    tbl[0] = '{0, 64'h8000_0010, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 0, 0, 1,
               64'h8000_0010, 1'b0, 64'h1122_3344_5566_7788};
    tbl[1] = '{1, 64'h8000_0020, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 64'h0, 3, 1, 1,
               64'h8000_0020, 1'b1, 64'h0};
    tbl[2] = '{2, 64'h8000_0004, 64'h0, 8'h00, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0, 3,
               64'h8000_0000, 1'b0, 64'h0000_0000_AAAA_BBBB};
    tbl[3] = '{2, 64'h8000_000B, 64'h0, 8'h00, 64'hAAAA_BBBB_CCCC_DDDD, 1, 2, 1,
               64'h8000_0008, 1'b0, 64'h0000_0000_CCCC_DDDD};
    tbl[4] = '{3, 64'h0000_1000, 64'h55, 8'hFF, 64'h77, 0, 0, 1,
               64'h0000_1000, 1'b1, 64'h77};
    tbl[5] = '{0, 64'h8000_0018, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 2, 3, 1,
               64'h8000_0018, 1'b0, 64'h0123_4567_89AB_CDEF};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset valids", {60'h0, inst_valid, mem_finish, bus_valid, bus_we}, 64'h0);
    chk("reset bus_addr", bus_addr, 64'h0);
    chk("reset bus_wdata", bus_wdata, 64'h0);
    chk("reset data_i", data_i, 64'h0);
    chk("reset inst/wmask", {24'h0, bus_wmask, inst}, 64'h0);
`ifdef BUS_ARB_TIMEOUT_EN
    chk("reset bus_err", 64'(bus_err), 64'h0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      do_txn(tbl[i].kind, tbl[i].addr, tbl[i].wd, tbl[i].wm, tbl[i].rd, tbl[i].rdy, tbl[i].rv,
             tbl[i].hold, tbl[i].ebaddr, tbl[i].ewe, tbl[i].eres, 1'b0, $sformatf("vec%0d", i));

    // Simultaneous data and fetch request: data first
    re = 1'b1; data_addr = 64'h8000_0030;
    inst_ena = 1'b1; inst_addr = 64'h8000_0104;
    @(negedge clk);
    chk("sim data first", {bus_valid, bus_we, bus_addr}, {1'b1, 1'b0, 64'h8000_0030});
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h0BAD_F00D_1234_5678;
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk("sim data finish", {mem_finish, data_i}, {1'b1, 64'h0BAD_F00D_1234_5678});
    re = 1'b0;
    @(negedge clk);
    chk("sim gap", 64'(bus_valid), 64'd0);
    @(negedge clk);
    chk("sim fetch follows", {bus_valid, bus_we, bus_addr}, {1'b1, 1'b0, 64'h8000_0100});
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h9999_8888_7777_6666;
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk("sim fetch inst", {inst_valid, inst}, {1'b1, 32'h9999_8888});
    inst_ena = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;

    // Redirect during I_WAIT
    inst_addr = 64'h100; inst_ena = 1'b1;
    @(negedge clk);
    chk("redir first addr", {bus_valid, bus_addr}, {1'b1, 64'h100});
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0; inst_addr = 64'h200;
    @(negedge clk);
    bus_rvalid = 1'b1; bus_rdata = 64'hFFFF_EEEE_DDDD_CCCC;
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk("redir discarded", {inst_valid, bus_valid}, 2'b00);
    @(negedge clk);
    chk("redir refetch", {bus_valid, bus_addr}, {1'b1, 64'h200});
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk("redir inst", {inst_valid, inst}, {1'b1, 32'h3333_4444});
    inst_ena = 1'b0; inst_addr = 64'h300;
    @(negedge clk);
    chk("hold flush", 64'(inst_valid), 64'd0);
    @(negedge clk);

    // Randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      a  = {$urandom, $urandom};
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      wm = 8'($urandom);
      do_txn(kind, a, wd, wm, rd, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(1, 3), m_baddr(kind, a), m_we(kind), m_res(kind, a, rd), 1'b1,
             $sformatf("rnd%0d", i));
    end

    // Reset in the middle of D_WAIT
    re = 1'b1; data_addr = 64'h8000_0040;
    @(negedge clk);
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    #2 rst = 1'b1; re = 1'b0;
    #1;
    chk("async reset outputs", {bus_valid, bus_we, mem_finish, inst_valid, bus_wmask, inst},
        64'h0);
    chk("async reset bus_addr", bus_addr, 64'h0);
    @(negedge clk);
    rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
    found = 0;
    repeat (3) begin
      @(negedge clk);
      bus_rvalid = 1'b0;
      if (mem_finish) found++;
    end
    chk("late rvalid ignored", {32'(found), 32'(data_i)}, 64'h0);

`ifdef BUS_ARB_TIMEOUT_EN
    // Watchdog: no response at all
    re = 1'b1; data_addr = 64'h10;
    found = 0;
    for (int c = 0; c < 60 && found == 0; c++) begin
      @(negedge clk);
      bus_ready = bus_valid;
      if (mem_finish) found = 1;
    end
    bus_ready = 1'b0; re = 1'b0;
    chk("timeout finish", 64'(found), 64'd1);
    chk("timeout data_i", data_i, 64'h0);
    chk("timeout bus_err", 64'(bus_err), 64'd1);
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
